// File: rtl/dff_mem_ctrl.sv
// Command sequencer in front of the 16-byte DFF memory: turns single and burst
// read/write commands into legal memory strobes and returns read data with back-pressure.
module dff_mem_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rin,
   output logic              mem_rout_n,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP} state_t;

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   remain_q;
   logic                cmd_ready_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_last_q;
   logic                busy_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                mem_rin_q;
   logic                mem_rout_n_q;

   logic [ADDR_W-1:0]   addr_inc;
   logic [ADDR_W-1:0]   beats_m1;

   // Address wraps modulo the memory depth; single ops carry exactly one beat.
   assign addr_inc = addr_q + ONE;
   assign beats_m1 = cmd_op[1] ? cmd_len : '0;

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_last   = rsp_last_q;
   assign busy       = busy_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_rin    = mem_rin_q;
   assign mem_rout_n = mem_rout_n_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         remain_q     <= '0;
         cmd_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_rin_q    <= 1'b0;
         mem_rout_n_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  addr_q      <= cmd_addr;
                  remain_q    <= beats_m1;
                  mem_addr_q  <= cmd_addr;
                  mem_wdata_q <= cmd_data;
                  // Strobes for the first beat go out in the very next cycle.
                  if (!cmd_op[0]) begin
                     state_q      <= WRITE;
                     mem_rin_q    <= 1'b0;
                     mem_rout_n_q <= 1'b0;
                  end else begin
                     state_q      <= RD_ISSUE;
                     mem_rin_q    <= 1'b1;
                     mem_rout_n_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (remain_q != '0) begin
                  addr_q     <= addr_inc;
                  mem_addr_q <= addr_inc;
                  remain_q   <= remain_q - ONE;
               end else begin
                  state_q      <= IDLE;
                  mem_rout_n_q <= 1'b1;
                  busy_q       <= 1'b0;
                  cmd_ready_q  <= 1'b1;
               end
            end
            RD_ISSUE: begin
               state_q   <= RD_WAIT;
               mem_rin_q <= 1'b0;
            end
            RD_WAIT: begin
               state_q     <= RESP;
               rsp_data_q  <= mem_rdata;
               rsp_valid_q <= 1'b1;
               rsp_last_q  <= (remain_q == '0);
            end
            RESP: begin
               // Memory stays idle for as long as the consumer stalls.
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  if (remain_q != '0) begin
                     state_q    <= RD_ISSUE;
                     addr_q     <= addr_inc;
                     mem_addr_q <= addr_inc;
                     remain_q   <= remain_q - ONE;
                     mem_rin_q  <= 1'b1;
                  end else begin
                     state_q     <= IDLE;
                     busy_q      <= 1'b0;
                     cmd_ready_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q      <= IDLE;
               mem_rin_q    <= 1'b0;
               mem_rout_n_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dff_mem_ctrl.sv
// Bench for dff_mem_ctrl: a DFF memory model on the strobe port plus a byte-array
// reference of memory contents that predicts every response.
module tb_dff_mem_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [3:0] cmd_addr = 4'd0;
   logic [3:0] cmd_len = 4'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_last;
   logic       busy;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_rin;
   logic       mem_rout_n;
   logic [7:0] mem_rdata;

   logic [7:0] dmem [16];
   logic [7:0] ref_mem [16];
   int tests_run = 0;
   int tests_failed = 0;
   int viol_strobe = 0;
   int viol_ready = 0;

   dff_mem_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rin(mem_rin),
      .mem_rout_n(mem_rout_n), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // DFF memory: write on (rin=0, rout_n=0), registered read on (rin=1, rout_n=1).
   always @(posedge clk) begin
      if (!mem_rin && !mem_rout_n) dmem[mem_addr] <= mem_wdata;
      if (mem_rin && mem_rout_n) mem_rdata <= dmem[mem_addr];
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rin && !mem_rout_n) viol_strobe++;
         if (busy && cmd_ready) viol_ready++;
      end
   end

   task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] l,
                           input logic [7:0] d, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l; cmd_data = d;
      for (int i = 0; i < 300; i++) begin
         if (cmd_ready === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      #1 cmd_valid = 1'b0;
      $display("[TB] cmd op=%0d addr=%0d len=%0d data=%02h accepted=%0d", op, a, l, d, ok);
      // Reference contents update at the command level.
      if (ok && op == 2'd0) ref_mem[a] = d;
      if (ok && op == 2'd2)
         for (int i = 0; i <= int'(l); i++) ref_mem[(int'(a) + i) % 16] = d;
   endtask

   task automatic recv_rsp(input int stall, output logic [7:0] d, output logic l, output bit ok,
                           output int wait_cyc, output bit stable, output bit strobe_seen);
      ok = 1'b0; stable = 1'b1; strobe_seen = 1'b0; wait_cyc = 0; d = 8'h00; l = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
         wait_cyc++;
      end
      if (ok) begin
         d = rsp_data; l = rsp_last;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (rsp_data !== d || rsp_last !== l || rsp_valid !== 1'b1) stable = 1'b0;
            if (mem_rin !== 1'b0) strobe_seen = 1'b1;
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0;
         $display("[TB] rsp data=%02h last=%0d wait=%0d", d, l, wait_cyc);
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      bit ok, okr, l, st, sb;
      logic [7:0] d;
      int w;
      @(negedge clk);
      tests_run++;
      if ({cmd_ready, rsp_valid, busy, mem_rin, mem_rout_n, mem_addr, mem_wdata, rsp_data, rsp_last} !== {5'b00001, 4'h0, 8'h00, 8'h00, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_values: got rdy=%b vld=%b busy=%b rin=%b rout_n=%b addr=%h wd=%h rd=%h last=%b required 0 0 0 0 1 0 00 00 0",
                  cmd_ready, rsp_valid, busy, mem_rin, mem_rout_n, mem_addr, mem_wdata, rsp_data, rsp_last);
      end
      rst = 1'b0;
      tests_run++;
      if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL ready_at_release: got %b required 0", cmd_ready); end
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_release: got %b required 1", cmd_ready); end
      // Reset in the middle of a fill.
      send_cmd(2'd2, 4'd0, 4'd15, 8'h77, ok);
      repeat (3) @(negedge clk);
      tests_run++;
      if (!ok || busy !== 1'b1 || mem_rout_n !== 1'b0) begin
         tests_failed++; $display("FAIL mid_fill_active: got ok=%b busy=%b rout_n=%b required 1 1 0", ok, busy, mem_rout_n);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({mem_rin, mem_rout_n, rsp_valid, cmd_ready, busy} !== 5'b01000) begin
         tests_failed++; $display("FAIL reset_immediate: got rin=%b rout_n=%b vld=%b rdy=%b busy=%b required 0 1 0 0 0",
                                  mem_rin, mem_rout_n, rsp_valid, cmd_ready, busy);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL abandoned_fill: got rdy=%b busy=%b required 1 0", cmd_ready, busy);
      end
      // Reset while a response is pending: it must never come back.
      send_cmd(2'd1, 4'd2, 4'd0, 8'h00, ok);
      repeat (4) @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL pending_rsp: got %b required 1", rsp_valid); end
      #2 rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      recv_rsp(0, d, l, okr, w, st, sb);
      tests_run++;
      if (okr !== 1'b0) begin tests_failed++; $display("FAIL dropped_rsp: got represented=%b required 0", okr); end
   endtask

   task automatic test_write_read;
      bit ok, l, st, sb;
      logic [7:0] d;
      int w;
      send_cmd(2'd0, 4'd3, 4'd9, 8'hA5, ok);
      @(negedge clk);
      tests_run++;
      if ({mem_rin, mem_rout_n, mem_addr, mem_wdata, busy, cmd_ready} !== {2'b00, 4'd3, 8'hA5, 2'b10}) begin
         tests_failed++; $display("FAIL write_beat: got rin=%b rout_n=%b addr=%0d wd=%h busy=%b rdy=%b required 0 0 3 a5 1 0",
                                  mem_rin, mem_rout_n, mem_addr, mem_wdata, busy, cmd_ready);
      end
      @(negedge clk);
      tests_run++;
      if ({cmd_ready, mem_rin, mem_rout_n, rsp_valid} !== 4'b1010) begin
         tests_failed++; $display("FAIL write_done: got rdy=%b rin=%b rout_n=%b vld=%b required 1 0 1 0",
                                  cmd_ready, mem_rin, mem_rout_n, rsp_valid);
      end
      send_cmd(2'd1, 4'd3, 4'd7, 8'h00, ok);
      recv_rsp(0, d, l, ok, w, st, sb);
      tests_run++;
      if (!ok || d !== ref_mem[3] || l !== 1'b1 || w != 2) begin
         tests_failed++; $display("FAIL read_single: got ok=%b data=%h last=%b latency=%0d required 1 %h 1 2",
                                  ok, d, l, w, ref_mem[3]);
      end
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_rsp: got %b required 1", cmd_ready); end
   endtask

   task automatic test_fill_dump;
      bit ok;
      int n_rsp, n_last, n_bad, cyc, last_idx;
      send_cmd(2'd2, 4'd0, 4'd15, 8'h3C, ok);
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) break;
         cyc++;
      end
      tests_run++;
      if (!ok || cyc != 16) begin tests_failed++; $display("FAIL fill_duration: got %0d cycles required 16", cyc); end
      rsp_ready = 1'b1;
      send_cmd(2'd3, 4'd0, 4'd15, 8'h00, ok);
      n_rsp = 0; n_last = 0; n_bad = 0; cyc = 0; last_idx = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) break;
         if (rsp_valid === 1'b1) begin
            if (rsp_data !== ref_mem[n_rsp % 16]) n_bad++;
            if (rsp_last === 1'b1) begin n_last++; last_idx = n_rsp; end
            n_rsp++;
         end
         cyc++;
      end
      rsp_ready = 1'b0;
      $display("[TB] dump 16 beats: rsp=%0d bad=%0d cycles=%0d", n_rsp, n_bad, cyc);
      tests_run++;
      if (n_rsp != 16 || n_bad != 0) begin
         tests_failed++; $display("FAIL dump_data: got %0d responses %0d wrong required 16 responses 0 wrong", n_rsp, n_bad);
      end
      tests_run++;
      if (n_last != 1 || last_idx != 15) begin
         tests_failed++; $display("FAIL dump_last: got %0d last flags at index %0d required 1 at 15", n_last, last_idx);
      end
      tests_run++;
      if (cyc != 48) begin tests_failed++; $display("FAIL dump_rate: got %0d cycles required 48", cyc); end
   endtask

   task automatic test_wrap;
      bit ok, l, st, sb;
      logic [7:0] d;
      int w;
      send_cmd(2'd2, 4'd14, 4'd2, 8'h11, ok);
      for (int k = 0; k < 4; k++) begin
         logic [3:0] a;
         a = 4'(14 + k);
         send_cmd(2'd1, a, 4'd0, 8'h00, ok);
         recv_rsp(0, d, l, ok, w, st, sb);
         tests_run++;
         if (!ok || d !== ref_mem[a] || d !== ((k < 3) ? 8'h11 : 8'h3C)) begin
            tests_failed++; $display("FAIL wrap_addr%0d: got %h required %h", a, d, (k < 3) ? 8'h11 : 8'h3C);
         end
      end
   endtask

   task automatic test_back_pressure;
      bit ok, l, st, sb;
      logic [7:0] d;
      int w;
      for (int k = 0; k < 4; k++) send_cmd(2'd0, 4'(5 + k), 4'd0, 8'(8'h50 + k), ok);
      send_cmd(2'd3, 4'd5, 4'd3, 8'h00, ok);
      for (int k = 0; k < 4; k++) begin
         recv_rsp(4, d, l, ok, w, st, sb);
         tests_run++;
         if (!ok || d !== ref_mem[5 + k] || l !== (k == 3) || !st || sb) begin
            tests_failed++; $display("FAIL backpressure_beat%0d: got ok=%b data=%h last=%b stable=%b strobe=%b required 1 %h %b 1 0",
                                     k, ok, d, l, st, sb, ref_mem[5 + k], (k == 3));
         end
      end
   endtask

   task automatic test_random;
      bit ok, l, st, sb;
      logic [7:0] d;
      int w, errs, n;
      logic [1:0] op;
      logic [3:0] a, ln;
      send_cmd(2'd2, 4'd0, 4'd15, 8'($urandom), ok);
      errs = 0;
      for (int c = 0; c < 30; c++) begin
         op = 2'($urandom_range(0, 3));
         a  = 4'($urandom);
         ln = 4'($urandom);
         send_cmd(op, a, ln, 8'($urandom), ok);
         if (!ok) errs++;
         if (ok && op[0]) begin
            n = op[1] ? int'(ln) + 1 : 1;
            for (int b = 0; b < n; b++) begin
               recv_rsp($urandom_range(0, 2), d, l, ok, w, st, sb);
               if (!ok || d !== ref_mem[(int'(a) + b) % 16] || l !== (b == n - 1) || !st) begin
                  errs++;
                  $display("[TB] random cmd %0d beat %0d: data=%h last=%b expected %h %b", c, b, d, l,
                           ref_mem[(int'(a) + b) % 16], (b == n - 1));
               end
            end
         end
      end
      wait_idle(ok);
      tests_run++;
      if (errs != 0 || !ok) begin tests_failed++; $display("FAIL random_stream: got %0d bad transactions required 0", errs); end
      tests_run++;
      if (viol_strobe != 0) begin tests_failed++; $display("FAIL strobe_conflict: got %0d cycles required 0", viol_strobe); end
      tests_run++;
      if (viol_ready != 0) begin tests_failed++; $display("FAIL ready_while_busy: got %0d cycles required 0", viol_ready); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_fill_dump;
      test_wrap;
      test_back_pressure;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
